// File: rtl/cpu_if_pkg.sv
// rtl/cpu_if_pkg.sv - shared widths and entry type for the fetch/decode boundary
package cpu_if_pkg;

    localparam int ADDR_W  = 30;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fq_ptr.sv
// rtl/fq_ptr.sv - wrap-around queue pointer with increment and clear
module fq_ptr #(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [PW-1:0] ptr
);

    // Clear wins over increment so a redirect always realigns the pointer to slot 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - IF/ID decoupling queue with PCWrite stall control
module if_fetch_queue
    import cpu_if_pkg::fetch_entry_t, cpu_if_pkg::NOP_INSTR;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 30,
    parameter int INSTR_W = 32,
    parameter int CW      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W+1:2]  PC,
    input  logic [INSTR_W-1:0] Instr,
    input  logic               fetch_valid,
    input  logic               flush,
    output logic               PCWrite,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [ADDR_W+1:2]  id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic [CW-1:0]      count
);

    localparam int PW = $clog2(DEPTH);

    logic         pop;
    logic         full;
    logic         accept;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    fetch_entry_t storage [DEPTH];
    fetch_entry_t head;

    // A pop frees a slot in the same cycle, so a full queue can still take a fetch
    // while decode drains it. Flush kills both sides of the handshake.
    assign id_valid = (count != '0);
    assign pop      = id_valid & id_ready & ~flush;
    assign full     = (count == CW'(DEPTH));
    assign accept   = fetch_valid & ~flush & (~full | pop);
    assign PCWrite  = accept | flush;

    assign head     = storage[rd_ptr];
    assign id_pc    = head.pc;
    assign id_instr = head.instr;

    fq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .clr   (flush),
        .ptr   (wr_ptr)
    );

    fq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop),
        .clr   (flush),
        .ptr   (rd_ptr)
    );

    // Entry storage; cleared on reset so the head outputs are never X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '{pc: '0, instr: NOP_INSTR};
            end
        end else if (accept) begin
            storage[wr_ptr] <= '{pc: PC, instr: Instr};
        end
    end

    // Occupancy: flush empties, simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (accept && !pop) begin
            count <= count + CW'(1);
        end else if (pop && !accept) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - scoreboard bench for if_fetch_queue
module tb_if_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:2] PC;
    logic [31:0] Instr;
    logic        fetch_valid;
    logic        flush;
    logic        PCWrite;
    logic        id_valid;
    logic        id_ready;
    logic [31:2] id_pc;
    logic [31:0] id_instr;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    int n_pops = 0;
    int m_cnt = 0;
    logic [61:0] sb [$];

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .PC          (PC),
        .Instr       (Instr),
        .fetch_valid (fetch_valid),
        .flush       (flush),
        .PCWrite     (PCWrite),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ins_of(input logic [29:0] pc);
        return 32'hE000_0000 | {2'b00, pc};
    endfunction

    // One fetch cycle. hpw/hcnt are hand-computed expectations; -1 falls back to the model.
    task automatic step(input logic fv, input logic [29:0] pc, input logic rdy,
                        input logic fl, input int hpw, input int hcnt, output logic acc);
        logic mpop, macc, epw;
        int ecnt;
        fetch_valid = fv;
        PC          = pc;
        Instr       = ins_of(pc);
        id_ready    = rdy;
        flush       = fl;
        @(negedge clk);
        mpop = (m_cnt != 0) && rdy && !fl;
        macc = fv && !fl && ((m_cnt < DEPTH) || mpop);
        epw  = (hpw >= 0) ? hpw[0] : (macc | fl);
        ecnt = (hcnt >= 0) ? hcnt : m_cnt;
        chk("pcwrite", 64'(PCWrite), 64'(epw));
        chk("count", 64'(count), 64'(ecnt));
        chk("id_valid", 64'(id_valid), 64'(ecnt != 0));
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
            m_cnt = 0;
        end else begin
            if (macc) sb.push_back({pc, ins_of(pc)});
            m_cnt = m_cnt + int'(macc) - int'(mpop);
        end
        acc = macc;
    endtask

    // Monitor: every handshake at the head must match the oldest expected entry.
    initial begin
        logic [61:0] e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && id_valid === 1'b1 && id_ready === 1'b1 && flush === 1'b0) begin
                n_pops++;
                if (sb.size() == 0) begin
                    chk("unexpected_pop", 64'(id_pc), 64'h0);
                end else begin
                    e = sb.pop_front();
                    chk("head_pc", 64'(id_pc), 64'(e[61:32]));
                    chk("head_instr", 64'(id_instr), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        int next;
        int pops0;
        reset = 1'b0;
        fetch_valid = 1'b0;
        flush = 1'b0;
        id_ready = 1'b0;
        PC = '0;
        Instr = '0;

        // 1: held in reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            fetch_valid = 1'($urandom);
            id_ready    = 1'($urandom);
            PC          = 30'($urandom);
            Instr       = $urandom;
            @(negedge clk);
            chk("rst_id_valid", 64'(id_valid), 64'h0);
            chk("rst_count", 64'(count), 64'h0);
            chk("rst_pcwrite", 64'(PCWrite), 64'(fetch_valid));
            chk("rst_id_pc", 64'(id_pc), 64'h0);
            chk("rst_id_instr", 64'(id_instr), 64'h0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 2: streaming, first entry accepted right after release
        step(1'b1, 30'hBFF, 1'b1, 1'b0, 1, 0, a);
        step(1'b1, 30'hC00, 1'b1, 1'b0, 1, 1, a);
        step(1'b1, 30'hC01, 1'b1, 1'b0, 1, 1, a);
        step(1'b0, 30'h0,   1'b1, 1'b0, 0, 1, a);
        step(1'b0, 30'h0,   1'b1, 1'b0, 0, 0, a);

        // 3: backpressure, then simultaneous pop and push into full queue
        step(1'b1, 30'h100, 1'b0, 1'b0, 1, 0, a);
        step(1'b1, 30'h101, 1'b0, 1'b0, 1, 1, a);
        step(1'b1, 30'h102, 1'b0, 1'b0, 1, 2, a);
        step(1'b1, 30'h103, 1'b0, 1'b0, 1, 3, a);
        step(1'b1, 30'h104, 1'b0, 1'b0, 0, 4, a);
        step(1'b1, 30'h104, 1'b1, 1'b0, 1, 4, a);
        step(1'b0, 30'h0,   1'b1, 1'b0, 0, 4, a);
        step(1'b0, 30'h0,   1'b1, 1'b0, 0, 3, a);
        step(1'b0, 30'h0,   1'b1, 1'b0, 0, 2, a);
        step(1'b0, 30'h0,   1'b1, 1'b0, 0, 1, a);
        step(1'b0, 30'h0,   1'b0, 1'b0, 0, 0, a);

        // 4: ten entries through the queue with alternating id_ready
        pops0 = n_pops;
        next = 'h200;
        for (int i = 0; i < 60 && next <= 'h209; i++) begin
            step(1'b1, 30'(next), 1'(i % 2), 1'b0, -1, -1, a);
            if (a) next++;
        end
        for (int i = 0; i < 10 && m_cnt != 0; i++) begin
            step(1'b0, 30'h0, 1'b1, 1'b0, -1, -1, a);
        end
        chk("wrap_pops", 64'(n_pops - pops0), 64'd10);
        chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

        // 5: flush with three entries queued
        step(1'b1, 30'h300, 1'b0, 1'b0, 1, 0, a);
        step(1'b1, 30'h301, 1'b0, 1'b0, 1, 1, a);
        step(1'b1, 30'h302, 1'b0, 1'b0, 1, 2, a);
        step(1'b1, 30'h303, 1'b1, 1'b1, 1, 3, a);
        step(1'b0, 30'h0,   1'b0, 1'b0, 0, 0, a);
        step(1'b1, 30'h310, 1'b1, 1'b0, 1, 0, a);
        step(1'b0, 30'h0,   1'b1, 1'b0, 0, 1, a);
        step(1'b0, 30'h0,   1'b1, 1'b0, 0, 0, a);

        // 6: asynchronous reset between edges with two entries held
        step(1'b1, 30'h400, 1'b0, 1'b0, 1, 0, a);
        step(1'b1, 30'h401, 1'b0, 1'b0, 1, 1, a);
        fetch_valid = 1'b0;
        id_ready = 1'b0;
        chk("pre_areset_count", 64'(count), 64'd2);
        #1;
        reset = 1'b0;
        #1;
        chk("areset_count", 64'(count), 64'h0);
        chk("areset_id_valid", 64'(id_valid), 64'h0);
        sb.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, 30'h410, 1'b1, 1'b0, 1, 0, a);
        step(1'b0, 30'h0,   1'b1, 1'b0, 0, 1, a);
        step(1'b0, 30'h0,   1'b0, 1'b0, 0, 0, a);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
